hex_uart_dump: RTL and testbench
================================

HEX_UART_DUMP -- requirements
Module: hex_uart_dump

Interface
REQ-001 The module SHALL provide parameter UPPERCASE, default 1: hex letters A-F are emitted as 0x41-0x46 when 1 and 0x61-0x66 when 0.
REQ-002 The module SHALL provide parameter LINE_END, default 1: CR (0x0D) then LF (0x0A) follow each word when 1; nothing follows when 0.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_i  input  128  result word, e.g. from hash_gen.
REQ-006 valid_i  input  1  one-cycle qualifier for data_i; has no backpressure.
REQ-007 tx_data  output  8  ASCII byte to uart_wrapper.
REQ-008 tx_valid  output  1  tx_data holds a byte.
REQ-009 tx_ready  input  1  uart_wrapper accepts the byte.
REQ-010 busy  output  1  high while the active word is not idle or the pending slot is full.
REQ-011 drop_cnt  output  8  count of discarded words, saturating.

Function
REQ-012 The block SHALL hold one active word (a shift register) and one pending slot.
REQ-013 The FSM SHALL have states IDLE, HEX, CR and LF; CR and LF SHALL be skipped when LINE_END=0.
REQ-014 A byte SHALL transfer only on a cycle where tx_valid=1 and tx_ready=1.
REQ-015 While tx_valid=1 and tx_ready=0, tx_data SHALL stay stable and tx_valid SHALL stay high.
REQ-016 tx_valid SHALL be 1 exactly in HEX, CR and LF.
REQ-017 In HEX, the emitted nibble order SHALL be data_i[127:124] first and data_i[3:0] last, giving 32 characters.
REQ-018 Nibble encoding SHALL be: 0-9 map to 0x30-0x39; 10-15 map per UPPERCASE.
REQ-019 A 6-bit nibble counter SHALL advance only on a transfer; the 32nd transfer SHALL leave HEX for CR, or for the word-end step when LINE_END=0.
REQ-020 CR SHALL move to LF on transfer; the LF transfer SHALL be the word-end step.
REQ-021 Word-end step:
- pending full: load pending into active, enter HEX, clear pending;
- otherwise, valid_i=1 that cycle: load data_i into active and enter HEX;
- otherwise: enter IDLE.
REQ-022 Latency: valid_i=1 in IDLE at cycle N SHALL load the active word directly, with tx_valid=1 and the first character at cycle N+1.
REQ-023 Back-to-back words SHALL have no idle cycle between the last byte of one word and the first byte of the next.
REQ-024 valid_i outside IDLE with pending empty SHALL write the pending slot.
REQ-025 valid_i with pending full SHALL still write the pending slot if the same cycle is a word-end step that consumes the pending word.
REQ-026 Any other valid_i while pending is full SHALL discard the word and increment drop_cnt.
REQ-027 drop_cnt SHALL saturate at 255.
REQ-028 busy SHALL be asserted when state is not IDLE or pending is full, and deasserted otherwise.

Reset
REQ-029 On assertion of reset, without waiting for clk, the block SHALL enter IDLE and clear the pending flag, the nibble counter and drop_cnt.
REQ-030 During reset, tx_valid=0, tx_data=0x00, busy=0 and drop_cnt=0.
REQ-031 Reset asserted mid-word SHALL abandon the word; tx_valid SHALL go 0 immediately.
REQ-032 After reset deasserts, the first valid_i SHALL start output at its first character.
REQ-033 Data registers need not be reset; all flags and counters SHALL be reset.

Verification
REQ-034 Basic stream: data_i=0x0123456789ABCDEFFEDCBA9876543210 with tx_ready=1 constant -> 34 bytes "0123456789ABCDEFFEDCBA9876543210\r\n", one per cycle, first at N+1; busy=0 after the LF transfer.
REQ-035 Backpressure: same word with tx_ready randomly low 50% of cycles -> identical byte sequence; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-036 Overflow: three valid_i pulses on consecutive cycles with tx_ready=0 (words 0x1..1, 0x2..2, 0x3..3) -> words 1 then 2 are output, word 3 never appears, drop_cnt=1; 300 further overflow drops -> drop_cnt=255.
REQ-037 Boundary: valid_i pulse on the same cycle as the final LF transfer, with pending full and with pending empty -> correct word order, no gap, no drop.
REQ-038 Parameters: UPPERCASE=0 with data 0xAB repeated -> bytes alternate 0x61,0x62; LINE_END=0 -> 32 bytes per word and back-to-back words contiguous.
REQ-039 Mid-word reset: reset asserted after the 10th transfer -> tx_valid=0 without a clock edge, busy=0, drop_cnt=0; the next word is emitted in full from its first character.

Source files
------------

// File: rtl/hex_uart_dump.sv
// Streams each 128-bit word as 32 ASCII hex characters (optionally followed by CR LF) to a byte sink.
// Holds one active word and one pending slot; words arriving when both are occupied are counted and dropped.
module hex_uart_dump #(
  parameter int UPPERCASE = 1,
  parameter int LINE_END  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;

  state_t       state, state_nxt;
  logic [127:0] active, pending;
  logic         pend_full, pend_full_nxt;
  logic [5:0]   nib_cnt, nib_cnt_nxt;
  logic         xfer, word_end;
  logic         load_data, load_pend, shift, wr_pend, drop_inc;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPERCASE != 0)
      return 8'h37 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  assign xfer = (state != IDLE) && tx_ready;
  assign busy = (state != IDLE) || pend_full;

  always_comb begin
    state_nxt     = state;
    nib_cnt_nxt   = nib_cnt;
    pend_full_nxt = pend_full;
    load_data     = 1'b0;
    load_pend     = 1'b0;
    shift         = 1'b0;
    wr_pend       = 1'b0;
    drop_inc      = 1'b0;
    word_end      = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;

    case (state)
      IDLE: begin
        if (valid_i) begin
          load_data   = 1'b1;
          nib_cnt_nxt = 6'd0;
          state_nxt   = HEX;
        end
      end
      HEX: begin
        tx_valid = 1'b1;
        tx_data  = hex_char(active[127:124]);
        if (xfer) begin
          shift       = 1'b1;
          nib_cnt_nxt = nib_cnt + 6'd1;
          if (nib_cnt == 6'd31) begin
            if (LINE_END != 0) state_nxt = CR;
            else               word_end  = 1'b1;
          end
        end
      end
      CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (xfer) state_nxt = LF;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (xfer) word_end = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (word_end) begin
      nib_cnt_nxt = 6'd0;
      if (pend_full) begin
        load_pend     = 1'b1;
        pend_full_nxt = 1'b0;
        state_nxt     = HEX;
      end else if (valid_i) begin
        load_data = 1'b1;
        state_nxt = HEX;
      end else begin
        state_nxt = IDLE;
      end
    end

    // A word-end that consumes the pending slot frees it for a word arriving the same cycle.
    if (valid_i && state != IDLE) begin
      if (word_end && pend_full) begin
        wr_pend       = 1'b1;
        pend_full_nxt = 1'b1;
      end else if (word_end) begin
        wr_pend = 1'b0;
      end else if (!pend_full) begin
        wr_pend       = 1'b1;
        pend_full_nxt = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      nib_cnt   <= 6'd0;
      pend_full <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      state     <= state_nxt;
      nib_cnt   <= nib_cnt_nxt;
      pend_full <= pend_full_nxt;
      if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (load_data)
      active <= data_i;
    else if (load_pend)
      active <= pending;
    else if (shift)
      active <= {active[123:0], 4'h0};
    if (wr_pend)
      pending <= data_i;
  end

endmodule

// File: tb/tb_hex_uart_dump.sv
// Scoreboarded bench for hex_uart_dump: default, lowercase and no-line-end instances share clock, reset and tx_ready.
module tb_hex_uart_dump;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_ready = 1'b0;
  logic         rand_mode = 1'b0;
  logic         rdy_force = 1'b1;

  logic [127:0] data_i = '0, d_lc = '0, d_nl = '0;
  logic         valid_i = 1'b0, v_lc = 1'b0, v_nl = 1'b0;
  logic [7:0]   tx_data, tx_data_lc, tx_data_nl;
  logic         tx_valid, tx_valid_lc, tx_valid_nl;
  logic         busy, busy_lc, busy_nl;
  logic [7:0]   drop_cnt, drop_lc, drop_nl;

  int asserts = 0;
  int fails = 0;
  int xfer0 = 0, xfer_nl = 0;
  logic [7:0] q0[$], q_lc[$], q_nl[$];

  hex_uart_dump dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  hex_uart_dump #(.UPPERCASE(0), .LINE_END(1)) dut_lc (
    .clk(clk), .reset(reset), .data_i(d_lc), .valid_i(v_lc),
    .tx_data(tx_data_lc), .tx_valid(tx_valid_lc), .tx_ready(tx_ready),
    .busy(busy_lc), .drop_cnt(drop_lc)
  );

  hex_uart_dump #(.UPPERCASE(1), .LINE_END(0)) dut_nl (
    .clk(clk), .reset(reset), .data_i(d_nl), .valid_i(v_nl),
    .tx_data(tx_data_nl), .tx_valid(tx_valid_nl), .tx_ready(tx_ready),
    .busy(busy_nl), .drop_cnt(drop_nl)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every accepted byte.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  always @(negedge clk) begin
    if (stall_prev && !reset) begin
      asserts++;
      if (!(tx_valid && tx_data == data_prev)) begin
        fails++;
        $display("FAIL stall_hold: valid=%0b data=%0h, expected valid=1 data=%0h", tx_valid, tx_data, data_prev);
      end
    end
    stall_prev = tx_valid && !tx_ready && !reset;
    data_prev  = tx_data;
    if (tx_valid && tx_ready) begin
      asserts++;
      xfer0++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL byte_main: got %0h, expected no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL byte_main: got %0h, expected %0h", tx_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tx_valid_lc && tx_ready) begin
      asserts++;
      if (q_lc.size() == 0) begin
        fails++;
        $display("FAIL byte_lc: got %0h, expected no byte", tx_data_lc);
      end else begin
        logic [7:0] e;
        e = q_lc.pop_front();
        if (tx_data_lc !== e) begin
          fails++;
          $display("FAIL byte_lc: got %0h, expected %0h", tx_data_lc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tx_valid_nl && tx_ready) begin
      asserts++;
      xfer_nl++;
      if (q_nl.size() == 0) begin
        fails++;
        $display("FAIL byte_nl: got %0h, expected no byte", tx_data_nl);
      end else begin
        logic [7:0] e;
        e = q_nl.pop_front();
        if (tx_data_nl !== e) begin
          fails++;
          $display("FAIL byte_nl: got %0h, expected %0h", tx_data_nl, e);
        end
      end
    end
  end

  task automatic push_byte(input int which, input logic [7:0] b);
    case (which)
      0:       q0.push_back(b);
      1:       q_lc.push_back(b);
      default: q_nl.push_back(b);
    endcase
  endtask

  task automatic push_str(input int which, input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) push_byte(which, s[i]);
    if (crlf) begin
      push_byte(which, 8'h0D);
      push_byte(which, 8'h0A);
    end
  endtask

  task automatic push_rep(input int which, input logic [7:0] c, input bit crlf);
    for (int i = 0; i < 32; i++) push_byte(which, c);
    if (crlf) begin
      push_byte(which, 8'h0D);
      push_byte(which, 8'h0A);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || busy_lc || busy_nl) && n < 3000) begin
      sample();
      n++;
    end
    asserts++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s: timeout, busy=%0b%0b%0b, expected idle", name, busy, busy_lc, busy_nl);
    end
    sample();
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_tx_data"},  32'(tx_data),  32'd0);
    check({name, "_busy"},     32'(busy),     32'd0);
    check({name, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [127:0] W_BASIC = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] W_A     = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W_B     = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] W_C     = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam string S_BASIC = "0123456789ABCDEFFEDCBA9876543210";
  localparam string S_A     = "00112233445566778899AABBCCDDEEFF";
  localparam string S_B     = "FFEEDDCCBBAA99887766554433221100";
  localparam string S_C     = "0F1E2D3C4B5A69788796A5B4C3D2E1F0";

  initial begin
    int base;
    #1;
    do_reset("reset0");

    // Basic stream: latency, contiguity, busy release.
    rdy_force = 1'b1;
    tick();
    tick();
    base = xfer0;
    push_str(0, S_BASIC, 1'b1);
    data_i = W_BASIC; valid_i = 1'b1;
    sample();
    check("basic_not_early", 32'(tx_valid), 32'd0);
    tick();
    valid_i = 1'b0;
    sample();
    check("basic_first_valid", 32'(tx_valid), 32'd1);
    check("basic_first_char", 32'(tx_data), 32'h30);
    repeat (33) sample();
    check("basic_34_contiguous", 32'(xfer0 - base), 32'd34);
    sample();
    check("basic_busy_after_lf", 32'(busy), 32'd0);
    check("basic_idle_after_lf", 32'(tx_valid), 32'd0);

    // Random backpressure.
    rand_mode = 1'b1;
    tick();
    push_str(0, S_BASIC, 1'b1);
    data_i = W_BASIC; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    wait_idle("bp_idle");
    rand_mode = 1'b0;
    rdy_force = 1'b1;
    tick();
    tick();

    // Boundary: new word on the LF transfer, pending empty.
    push_str(0, S_A, 1'b1);
    push_str(0, S_B, 1'b1);
    data_i = W_A; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    data_i = W_B; valid_i = 1'b1;
    sample();
    check("bnd_empty_on_lf", 32'(tx_data), 32'h0A);
    tick();
    valid_i = 1'b0;
    sample();
    check("bnd_empty_no_gap", 32'({tx_valid, tx_data}), 32'h146);
    wait_idle("bnd_empty_idle");

    // Boundary: new word on the LF transfer, pending full.
    tick();
    push_str(0, S_A, 1'b1);
    push_str(0, S_B, 1'b1);
    push_str(0, S_C, 1'b1);
    data_i = W_A; valid_i = 1'b1;
    tick();
    data_i = W_B;
    tick();
    valid_i = 1'b0;
    repeat (32) tick();
    data_i = W_C; valid_i = 1'b1;
    sample();
    check("bnd_full_on_lf", 32'(tx_data), 32'h0A);
    tick();
    valid_i = 1'b0;
    sample();
    check("bnd_full_no_gap", 32'({tx_valid, tx_data}), 32'h146);
    check("bnd_full_pending", 32'(busy), 32'd1);
    wait_idle("bnd_full_idle");
    check("bnd_no_drop", 32'(drop_cnt), 32'd0);

    // Parameter variants.
    tick();
    for (int i = 0; i < 16; i++) begin
      push_byte(1, 8'h61);
      push_byte(1, 8'h62);
    end
    push_byte(1, 8'h0D);
    push_byte(1, 8'h0A);
    push_str(2, S_BASIC, 1'b0);
    push_str(2, S_C, 1'b0);
    base = xfer_nl;
    d_lc = {16{8'hAB}}; v_lc = 1'b1;
    d_nl = W_BASIC; v_nl = 1'b1;
    tick();
    v_lc = 1'b0;
    d_nl = W_C;
    tick();
    v_nl = 1'b0;
    @(negedge clk);
    repeat (62) @(negedge clk);
    #1;
    check("nl_64_contiguous", 32'(xfer_nl - base), 32'd64);
    sample();
    check("nl_idle_after", 32'(tx_valid_nl), 32'd0);
    wait_idle("param_idle");

    // Overflow and saturation.
    rdy_force = 1'b0;
    tick();
    tick();
    push_rep(0, 8'h31, 1'b1);
    push_rep(0, 8'h32, 1'b1);
    data_i = {32{4'h1}}; valid_i = 1'b1;
    tick();
    data_i = {32{4'h2}};
    tick();
    data_i = {32{4'h3}};
    tick();
    valid_i = 1'b0;
    sample();
    check("ovf_drop_one", 32'(drop_cnt), 32'd1);
    tick();
    valid_i = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    valid_i = 1'b0;
    sample();
    check("ovf_drop_sat", 32'(drop_cnt), 32'd255);
    rdy_force = 1'b1;
    wait_idle("ovf_idle");
    check("ovf_queue_empty", 32'(q0.size()), 32'd0);

    // Mid-word reset after the 10th transfer.
    tick();
    base = xfer0;
    push_str(0, S_BASIC, 1'b1);
    data_i = W_BASIC; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_ten_xfers", 32'(xfer0 - base), 32'd10);
    q0.delete();
    do_reset("midrst");
    tick();
    push_str(0, S_C, 1'b1);
    data_i = W_C; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    sample();
    check("midrst_restart_char", 32'({tx_valid, tx_data}), 32'h130);
    wait_idle("midrst_idle");

    check("end_q_main", 32'(q0.size()), 32'd0);
    check("end_q_lc", 32'(q_lc.size()), 32'd0);
    check("end_q_nl", 32'(q_nl.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
